board_referee: RTL and testbench
================================

# board_referee

Responder side of the tic-tac-toe move interface: accepts move requests from a player source (the automatic player or the button-driven human player), validates them against the board it owns, and writes accepted moves into its nine 2-bit cells. After every accepted move it scans the eight winning lines sequentially and reports winner, draw and game-over status to the top-level game controller and display logic.

## Interface
Parameters:
- CHECK_LINES, 8, number of winning lines scanned per move; fixed at 8, not overridable in use.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; highest priority.
- new_game  in  1  synchronous clear of board and status; priority below reset, above moves.
- move_valid  in  1  requester presents a move.
- move_pos  in  4  target cell 0..8, row-major (0 = top-left, 8 = bottom-right).
- move_player  in  2  player ID: 01 = player 1, 10 = player 2.
- move_ready  out  1  high only in IDLE.
- move_ack  out  1  one-cycle pulse, move accepted.
- move_err  out  1  one-cycle pulse, move rejected.
- board  out  18  cell k at bits [2k+1:2k]; 00 empty, 01 P1, 10 P2.
- winner  out  2  00 none/draw, 01 P1, 10 P2.
- game_over  out  1  win or draw reached.
- turn_count  out  4  accepted moves this game, 0..9.

## Operation
- States: IDLE, CHECK, OVER. Line index register idx (3 bits) used in CHECK.
- Handshake: transfer when move_valid && move_ready at a rising edge. Requester holds inputs until transfer or error.
- Rejection in IDLE (move_err pulse, no state/board change, stay IDLE) if any: move_pos > 8; move_player not 01/10; target cell non-zero; move_player != expected (01 when turn_count even, 10 when odd).
- Acceptance: write move_player into cell, turn_count += 1, move_ack pulse, idx = 0, go CHECK.
- CHECK: one line per cycle, order idx 0..7: rows (0,1,2),(3,4,5),(6,7,8); columns (0,3,6),(1,4,7),(2,5,8); diagonals (0,4,8),(2,4,6).
  - Line cells equal and non-zero: winner = that value, game_over = 1, go OVER (remaining lines not scanned).
  - idx = 7, no win, turn_count = 9: winner = 00, game_over = 1, go OVER (draw).
  - idx = 7, no win, turn_count < 9: go IDLE.
  - Otherwise idx += 1.
- OVER: move_ready = 0; move_valid ignored (no ack, no err). Exit only by new_game or reset.
- new_game in any state: board = 0, turn_count = 0, winner = 00, game_over = 0, idx = 0, go IDLE; an in-flight CHECK is abandoned.
- move_ack and move_err are never high in the same cycle; neither is high outside the cycle after a handshake/rejection.

## Timing
- Reset (and new_game) values: board 0, winner 00, game_over 0, turn_count 0, move_ack 0, move_err 0, state IDLE, move_ready 1 from the next cycle.
- Handshake at edge T: move_ack/move_err high during cycle T..T+1 only; board and turn_count updated at T (visible after edge T).
- Winning line at index i: game_over and winner visible after edge T+1+i; move_ready stays 0.
- No win: move_ready returns high after edge T+8 (8 CHECK cycles); a new move can transfer at edge T+9 earliest.
- Draw: game_over visible after edge T+8.
- move_valid during CHECK/OVER: ignored, must not produce err.
- reset or new_game coincident with a handshake: clear wins, move not written, no ack.

## Test plan
- Reset: assert reset 2 cycles -> board=0, turn_count=0, game_over=0, winner=00, move_ready=1; no ack/err pulses.
- Accept: P1 move_pos=4 -> move_ack 1 cycle, board[9:8]=01, turn_count=1, move_ready low 8 cycles then high.
- Rejections: P2 to pos 4 (occupied) -> move_err; P1 when P2 expected -> move_err; move_pos=9 -> move_err; move_player=11 -> move_err; board and turn_count unchanged, move_ready stays 1.
- Row win: P1 0, P2 3, P1 1, P2 4, P1 2 -> after 5th handshake at T, winner=01 and game_over=1 visible after T+1 (idx 0); further move_valid ignored.
- Draw: sequence 0,1,2,4,3,5,7,6,8 (alternating P1/P2) -> turn_count=9, winner=00, game_over=1 after T+8 of the last move.
- Abort: new_game asserted mid-CHECK (cycle T+3) -> board=0, turn_count=0, IDLE next cycle, no game_over; repeat with reset, identical result.

Source files
------------

// File: rtl/board_referee.sv
// Tic-tac-toe referee: validates and applies move requests, then scans the
// eight winning lines one per cycle to report winner, draw and game-over status.
module board_referee #(
  parameter int CHECK_LINES = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        new_game,
  input  logic        move_valid,
  input  logic [3:0]  move_pos,
  input  logic [1:0]  move_player,
  output logic        move_ready,
  output logic        move_ack,
  output logic        move_err,
  output logic [17:0] board,
  output logic [1:0]  winner,
  output logic        game_over,
  output logic [3:0]  turn_count
);

  typedef enum logic [1:0] {IDLE, CHECK, OVER} state_t;

  localparam logic [2:0] LAST_LINE = 3'(CHECK_LINES - 1);

  state_t     state;
  logic [2:0] idx;

  logic [3:0]  pos_a, pos_b, pos_c;
  logic [1:0]  cell_a, cell_b, cell_c;
  logic [1:0]  target_cell;
  logic [1:0]  expected_player;
  logic        move_legal;
  logic        line_won;

  function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] pos);
    logic [1:0] v;
    case (pos)
      4'd0:    v = b[1:0];
      4'd1:    v = b[3:2];
      4'd2:    v = b[5:4];
      4'd3:    v = b[7:6];
      4'd4:    v = b[9:8];
      4'd5:    v = b[11:10];
      4'd6:    v = b[13:12];
      4'd7:    v = b[15:14];
      4'd8:    v = b[17:16];
      default: v = 2'b00;
    endcase
    return v;
  endfunction

  // Rows, then columns, then the two diagonals.
  always_comb begin
    pos_a = 4'd0;
    pos_b = 4'd1;
    pos_c = 4'd2;
    case (idx)
      3'd0: begin pos_a = 4'd0; pos_b = 4'd1; pos_c = 4'd2; end
      3'd1: begin pos_a = 4'd3; pos_b = 4'd4; pos_c = 4'd5; end
      3'd2: begin pos_a = 4'd6; pos_b = 4'd7; pos_c = 4'd8; end
      3'd3: begin pos_a = 4'd0; pos_b = 4'd3; pos_c = 4'd6; end
      3'd4: begin pos_a = 4'd1; pos_b = 4'd4; pos_c = 4'd7; end
      3'd5: begin pos_a = 4'd2; pos_b = 4'd5; pos_c = 4'd8; end
      3'd6: begin pos_a = 4'd0; pos_b = 4'd4; pos_c = 4'd8; end
      3'd7: begin pos_a = 4'd2; pos_b = 4'd4; pos_c = 4'd6; end
      default: begin pos_a = 4'd0; pos_b = 4'd1; pos_c = 4'd2; end
    endcase
  end

  always_comb begin
    cell_a          = cell_at(board, pos_a);
    cell_b          = cell_at(board, pos_b);
    cell_c          = cell_at(board, pos_c);
    line_won        = (cell_a != 2'b00) && (cell_a == cell_b) && (cell_b == cell_c);
    target_cell     = cell_at(board, move_pos);
    expected_player = turn_count[0] ? 2'b10 : 2'b01;
    move_legal      = (move_pos <= 4'd8)
                   && ((move_player == 2'b01) || (move_player == 2'b10))
                   && (target_cell == 2'b00)
                   && (move_player == expected_player);
  end

  // new_game shares the reset path so an in-flight scan is simply dropped.
  always_ff @(posedge clock) begin
    if (reset || new_game) begin
      state      <= IDLE;
      idx        <= 3'd0;
      board      <= 18'd0;
      winner     <= 2'b00;
      game_over  <= 1'b0;
      turn_count <= 4'd0;
      move_ack   <= 1'b0;
      move_err   <= 1'b0;
      move_ready <= 1'b1;
    end else begin
      move_ack <= 1'b0;
      move_err <= 1'b0;
      case (state)
        IDLE: begin
          if (move_valid) begin
            if (move_legal) begin
              for (int k = 0; k < 9; k++) begin
                if (move_pos == 4'(k)) board[2*k +: 2] <= move_player;
              end
              turn_count <= turn_count + 4'd1;
              move_ack   <= 1'b1;
              idx        <= 3'd0;
              move_ready <= 1'b0;
              state      <= CHECK;
            end else begin
              move_err <= 1'b1;
            end
          end
        end
        CHECK: begin
          if (line_won) begin
            winner    <= cell_a;
            game_over <= 1'b1;
            state     <= OVER;
          end else if (idx == LAST_LINE) begin
            if (turn_count == 4'd9) begin
              winner    <= 2'b00;
              game_over <= 1'b1;
              state     <= OVER;
            end else begin
              move_ready <= 1'b1;
              state      <= IDLE;
            end
          end else begin
            idx <= idx + 3'd1;
          end
        end
        OVER: begin
          move_ready <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          move_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_board_referee.sv
// Directed bench for board_referee: reset, accept/reject, row win, draw and
// mid-scan abort by new_game and by reset.
module tb_board_referee;

  logic        clock = 1'b0;
  logic        reset;
  logic        new_game;
  logic        move_valid;
  logic [3:0]  move_pos;
  logic [1:0]  move_player;
  logic        move_ready;
  logic        move_ack;
  logic        move_err;
  logic [17:0] board;
  logic [1:0]  winner;
  logic        game_over;
  logic [3:0]  turn_count;

  int compared   = 0;
  int mismatched = 0;

  board_referee #(.CHECK_LINES(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .new_game    (new_game),
    .move_valid  (move_valid),
    .move_pos    (move_pos),
    .move_player (move_player),
    .move_ready  (move_ready),
    .move_ack    (move_ack),
    .move_err    (move_err),
    .board       (board),
    .winner      (winner),
    .game_over   (game_over),
    .turn_count  (turn_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [3:0] pos, input logic [1:0] player);
    move_valid  = valid;
    move_pos    = pos;
    move_player = player;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Accepted move with no win expected: ack at T, ready back after T+8.
  task automatic playMove(input logic [3:0] pos, input logic [1:0] player);
    applyStimulus(1'b1, pos, player);
    tick();
    checkOutput("play_ack", {31'd0, move_ack}, 32'd1);
    applyStimulus(1'b0, 4'd0, 2'b00);
    repeat (7) tick();
    checkOutput("play_busy", {31'd0, move_ready}, 32'd0);
    tick();
    checkOutput("play_ready", {31'd0, move_ready}, 32'd1);
    checkOutput("play_no_over", {31'd0, game_over}, 32'd0);
  endtask

  task automatic reject(input string tag, input logic [3:0] pos, input logic [1:0] player);
    applyStimulus(1'b1, pos, player);
    tick();
    checkOutput({tag, "_err"}, {31'd0, move_err}, 32'd1);
    checkOutput({tag, "_ack"}, {31'd0, move_ack}, 32'd0);
    checkOutput({tag, "_ready"}, {31'd0, move_ready}, 32'd1);
    applyStimulus(1'b0, 4'd0, 2'b00);
    tick();
    checkOutput({tag, "_err_drop"}, {31'd0, move_err}, 32'd0);
  endtask

  task automatic startGame();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    tick();
  endtask

  initial begin
    reset    = 1'b1;
    new_game = 1'b0;
    applyStimulus(1'b0, 4'd0, 2'b00);

    repeat (2) tick();
    reset = 1'b0;
    tick();
    checkOutput("rst_board", {14'd0, board}, 32'd0);
    checkOutput("rst_turn", {28'd0, turn_count}, 32'd0);
    checkOutput("rst_over", {31'd0, game_over}, 32'd0);
    checkOutput("rst_winner", {30'd0, winner}, 32'd0);
    checkOutput("rst_ready", {31'd0, move_ready}, 32'd1);
    checkOutput("rst_ack", {31'd0, move_ack}, 32'd0);
    checkOutput("rst_err", {31'd0, move_err}, 32'd0);

    // P1 takes the centre.
    applyStimulus(1'b1, 4'd4, 2'b01);
    tick();
    checkOutput("acc_ack", {31'd0, move_ack}, 32'd1);
    checkOutput("acc_err", {31'd0, move_err}, 32'd0);
    checkOutput("acc_board", {14'd0, board}, 32'h00100);
    checkOutput("acc_turn", {28'd0, turn_count}, 32'd1);
    checkOutput("acc_ready_T", {31'd0, move_ready}, 32'd0);
    applyStimulus(1'b0, 4'd0, 2'b00);
    tick();
    checkOutput("acc_ack_drop", {31'd0, move_ack}, 32'd0);
    for (int i = 2; i <= 7; i++) begin
      tick();
      checkOutput("acc_ready_busy", {31'd0, move_ready}, 32'd0);
    end
    tick();
    checkOutput("acc_ready_back", {31'd0, move_ready}, 32'd1);
    checkOutput("acc_no_over", {31'd0, game_over}, 32'd0);

    reject("rej_occupied", 4'd4, 2'b10);
    reject("rej_wrong_turn", 4'd0, 2'b01);
    reject("rej_pos9", 4'd9, 2'b10);
    reject("rej_player11", 4'd0, 2'b11);
    checkOutput("rej_board", {14'd0, board}, 32'h00100);
    checkOutput("rej_turn", {28'd0, turn_count}, 32'd1);

    // Row 0 win by P1.
    startGame();
    checkOutput("ng_board", {14'd0, board}, 32'd0);
    checkOutput("ng_turn", {28'd0, turn_count}, 32'd0);
    playMove(4'd0, 2'b01);
    playMove(4'd3, 2'b10);
    playMove(4'd1, 2'b01);
    playMove(4'd4, 2'b10);
    applyStimulus(1'b1, 4'd2, 2'b01);
    tick();
    checkOutput("win_ack", {31'd0, move_ack}, 32'd1);
    checkOutput("win_over_T", {31'd0, game_over}, 32'd0);
    applyStimulus(1'b1, 4'd5, 2'b10);
    tick();
    checkOutput("win_over", {31'd0, game_over}, 32'd1);
    checkOutput("win_winner", {30'd0, winner}, 32'd1);
    checkOutput("win_ready", {31'd0, move_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("over_no_ack", {31'd0, move_ack}, 32'd0);
      checkOutput("over_no_err", {31'd0, move_err}, 32'd0);
    end
    applyStimulus(1'b0, 4'd0, 2'b00);
    checkOutput("over_board", {14'd0, board}, 32'h00295);
    checkOutput("over_turn", {28'd0, turn_count}, 32'd5);
    checkOutput("over_winner_hold", {30'd0, winner}, 32'd1);

    // Full board with no line: draw.
    startGame();
    playMove(4'd0, 2'b01);
    playMove(4'd1, 2'b10);
    playMove(4'd2, 2'b01);
    playMove(4'd4, 2'b10);
    playMove(4'd3, 2'b01);
    playMove(4'd5, 2'b10);
    playMove(4'd7, 2'b01);
    playMove(4'd6, 2'b10);
    applyStimulus(1'b1, 4'd8, 2'b01);
    tick();
    checkOutput("draw_ack", {31'd0, move_ack}, 32'd1);
    applyStimulus(1'b0, 4'd0, 2'b00);
    repeat (7) tick();
    checkOutput("draw_not_yet", {31'd0, game_over}, 32'd0);
    tick();
    checkOutput("draw_over", {31'd0, game_over}, 32'd1);
    checkOutput("draw_winner", {30'd0, winner}, 32'd0);
    checkOutput("draw_turn", {28'd0, turn_count}, 32'd9);
    checkOutput("draw_board", {14'd0, board}, 32'h16A59);
    checkOutput("draw_ready", {31'd0, move_ready}, 32'd0);

    // Abort a scan with new_game at T+3, then with reset.
    startGame();
    for (int pass = 0; pass < 2; pass++) begin
      applyStimulus(1'b1, 4'd4, 2'b01);
      tick();
      applyStimulus(1'b0, 4'd0, 2'b00);
      repeat (2) tick();
      if (pass == 0) new_game = 1'b1;
      else           reset    = 1'b1;
      tick();
      new_game = 1'b0;
      reset    = 1'b0;
      checkOutput("abort_board", {14'd0, board}, 32'd0);
      checkOutput("abort_turn", {28'd0, turn_count}, 32'd0);
      checkOutput("abort_ready", {31'd0, move_ready}, 32'd1);
      checkOutput("abort_over", {31'd0, game_over}, 32'd0);
      repeat (8) tick();
      checkOutput("abort_stay_idle", {31'd0, move_ready}, 32'd1);
      checkOutput("abort_still_clear", {31'd0, game_over}, 32'd0);
    end

    // Clear coincident with a handshake wins over the move.
    applyStimulus(1'b1, 4'd0, 2'b01);
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    checkOutput("ng_hs_ack", {31'd0, move_ack}, 32'd0);
    checkOutput("ng_hs_board", {14'd0, board}, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("rst_hs_ack", {31'd0, move_ack}, 32'd0);
    checkOutput("rst_hs_turn", {28'd0, turn_count}, 32'd0);
    applyStimulus(1'b0, 4'd0, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
